cache_cam_evict: RTL and testbench

- Parametrised, fully associative CAM for cache page management with a per-page data payload.
- Supports pipelined lookup, store, erase and done commands, plus automatic ejection of DONE pages when the cache is full.
- Supports direct page clear and a sequenced full flush.
- Sits between the command front end and the page buffer controller. Provides a fixed-latency response for every accepted request.

---
 rtl/cache_cam_evict.sv | 356 +++++++++++++++++++++++++++++++++++
 tb/tb_cache_cam_evict.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_cam_evict.sv
// ---------------------------------------------------------------------------
// cache_cam_evict
//
// Fully associative CAM that manages cache pages. Each page holds a key, a
// data payload and a status (FREE / VALID / DONE). Requests go through a
// two-edge pipeline:
//   edge 1 : request captured into stage S1
//   cycle  : key compared against every non-FREE page, operation resolved
//   edge 2 : table written and response registered (rsp_valid for 1 cycle)
// Because the table is written at the same edge that the following request
// enters S1, back-to-back requests on one key see each other's effects
// without any forwarding path.
//
// A STORE that misses takes the lowest FREE page. If there is none, it
// ejects the lowest DONE page. If there is neither, it is rejected.
// Pages can also be freed one at a time (clr_en) or all at once (flush).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high. req_ready depends only on flush state, never on
// req_valid, and is low while a flush is starting or running.
//
// Optional feature (macro CACHE_CAM_EVICT_STATS_EN): adds stats_clr and the
// saturating 32-bit counters hit_cnt, miss_cnt and evict_cnt.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_cmd             0 NOP, 1 LOOKUP, 2 STORE, 3 ERASE, 4 DONE (5-7 NOP)
//   req_key, req_data   search key and STORE payload
//   clr_en, clr_page_addr  free one page at the next edge
//   flush_start, flush_busy  sequenced clear of every page
//   rsp_valid, rsp_cmd, rsp_hit, rsp_addr, rsp_data, rsp_status,
//   rsp_evict, rsp_evict_key, rsp_full   registered response
//   occupancy           number of non-FREE pages
//   stats_clr, hit_cnt, miss_cnt, evict_cnt   (only with the macro)
// ---------------------------------------------------------------------------
module cache_cam_evict #(
    parameter int PAGES      = 32,
    parameter int KEY_WIDTH  = 14,
    parameter int DATA_WIDTH = 8,
    parameter int AWIDTH     = $clog2(PAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_cmd,
    input  logic [KEY_WIDTH-1:0]  req_key,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  clr_en,
    input  logic [AWIDTH-1:0]     clr_page_addr,
    input  logic                  flush_start,
    output logic                  flush_busy,
`ifdef CACHE_CAM_EVICT_STATS_EN
    input  logic                  stats_clr,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [31:0]           evict_cnt,
`endif
    output logic                  rsp_valid,
    output logic [2:0]            rsp_cmd,
    output logic                  rsp_hit,
    output logic [AWIDTH-1:0]     rsp_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]            rsp_status,
    output logic                  rsp_evict,
    output logic [KEY_WIDTH-1:0]  rsp_evict_key,
    output logic                  rsp_full,
    output logic [AWIDTH:0]       occupancy
);

    localparam logic [2:0] CMD_LOOKUP = 3'd1;
    localparam logic [2:0] CMD_STORE  = 3'd2;
    localparam logic [2:0] CMD_ERASE  = 3'd3;
    localparam logic [2:0] CMD_DONE   = 3'd4;

    localparam logic [1:0] ST_FREE  = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [AWIDTH:0]   OCC_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] LAST_PG  = AWIDTH'(PAGES - 1);
    localparam logic [AWIDTH-1:0] ADDR_ONE = AWIDTH'(1);

    // Page table
    logic [KEY_WIDTH-1:0]  page_key  [PAGES];
    logic [DATA_WIDTH-1:0] page_data [PAGES];
    logic [1:0]            page_stat [PAGES];

    // Stage S1
    logic                  s1_valid;
    logic [2:0]            s1_cmd;
    logic [KEY_WIDTH-1:0]  s1_key;
    logic [DATA_WIDTH-1:0] s1_data;

    // Flush sequencer
    typedef enum logic {FL_IDLE, FL_RUN} flush_state_t;
    flush_state_t      flush_state;
    logic [AWIDTH-1:0] flush_cnt;

    assign req_ready = !flush_busy && !flush_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_cmd   <= '0;
            s1_key   <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= req_valid && req_ready;
            s1_cmd   <= req_cmd;
            s1_key   <= req_key;
            s1_data  <= req_data;
        end
    end

    // Parallel compare and free/done priority search (lowest index wins:
    // iterating downward lets the lowest matching index overwrite last).
    logic              match_hit, free_found, done_found;
    logic [AWIDTH-1:0] match_addr, free_addr, done_addr;

    always_comb begin
        match_hit  = 1'b0;
        match_addr = '0;
        free_found = 1'b0;
        free_addr  = '0;
        done_found = 1'b0;
        done_addr  = '0;
        for (int i = PAGES - 1; i >= 0; i--) begin
            if (page_stat[i] != ST_FREE && page_key[i] == s1_key) begin
                match_hit  = 1'b1;
                match_addr = AWIDTH'(i);
            end
            if (page_stat[i] == ST_FREE) begin
                free_found = 1'b1;
                free_addr  = AWIDTH'(i);
            end
            if (page_stat[i] == ST_DONE) begin
                done_found = 1'b1;
                done_addr  = AWIDTH'(i);
            end
        end
    end

    // Operation resolve: one table write plus the next response
    logic                  wr_en;
    logic [AWIDTH-1:0]     wr_addr;
    logic [KEY_WIDTH-1:0]  wr_key;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [1:0]            wr_stat;
    logic                  alloc_inc, erase_dec;
    logic [2:0]            nx_cmd;
    logic                  nx_hit, nx_evict, nx_full;
    logic [AWIDTH-1:0]     nx_addr;
    logic [DATA_WIDTH-1:0] nx_data;
    logic [1:0]            nx_status;
    logic [KEY_WIDTH-1:0]  nx_evict_key;

    always_comb begin
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_key       = '0;
        wr_data      = '0;
        wr_stat      = ST_FREE;
        alloc_inc    = 1'b0;
        erase_dec    = 1'b0;
        nx_cmd       = s1_valid ? s1_cmd : 3'd0;
        nx_hit       = 1'b0;
        nx_addr      = '0;
        nx_data      = '0;
        nx_status    = ST_FREE;
        nx_evict     = 1'b0;
        nx_evict_key = '0;
        nx_full      = 1'b0;
        if (s1_valid) begin
            case (s1_cmd)
                CMD_LOOKUP: begin
                    if (match_hit) begin
                        nx_hit    = 1'b1;
                        nx_addr   = match_addr;
                        nx_data   = page_data[match_addr];
                        nx_status = page_stat[match_addr];
                    end
                end
                CMD_STORE: begin
                    if (match_hit || free_found || done_found) begin
                        wr_en     = 1'b1;
                        wr_key    = s1_key;
                        wr_data   = s1_data;
                        wr_stat   = ST_VALID;
                        nx_data   = s1_data;
                        nx_status = ST_VALID;
                        if (match_hit) begin
                            wr_addr = match_addr;
                            nx_hit  = 1'b1;
                        end else if (free_found) begin
                            wr_addr   = free_addr;
                            alloc_inc = 1'b1;
                        end else begin
                            // Ejecting a DONE page leaves occupancy unchanged
                            wr_addr      = done_addr;
                            nx_evict     = 1'b1;
                            nx_evict_key = page_key[done_addr];
                        end
                        nx_addr = wr_addr;
                    end else begin
                        nx_full = 1'b1;
                    end
                end
                CMD_ERASE: begin
                    if (match_hit) begin
                        wr_en     = 1'b1;
                        wr_addr   = match_addr;
                        erase_dec = 1'b1;
                        nx_hit    = 1'b1;
                        nx_addr   = match_addr;
                    end
                end
                CMD_DONE: begin
                    if (match_hit) begin
                        wr_en     = 1'b1;
                        wr_addr   = match_addr;
                        wr_key    = page_key[match_addr];
                        wr_data   = page_data[match_addr];
                        wr_stat   = ST_DONE;
                        nx_hit    = 1'b1;
                        nx_addr   = match_addr;
                        nx_data   = page_data[match_addr];
                        nx_status = ST_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // A direct clear is dropped when S1 writes the same page this cycle
    logic clr_apply, clr_dec, flush_dec;
    assign clr_apply = clr_en && !flush_busy && !(wr_en && wr_addr == clr_page_addr);
    assign clr_dec   = clr_apply && page_stat[clr_page_addr] != ST_FREE;
    assign flush_dec = flush_busy && page_stat[flush_cnt] != ST_FREE;

    logic [AWIDTH:0] occ_next;
    always_comb begin
        occ_next = occupancy;
        if (alloc_inc) occ_next = occ_next + OCC_ONE;
        if (erase_dec) occ_next = occ_next - OCC_ONE;
        if (clr_dec)   occ_next = occ_next - OCC_ONE;
        if (flush_dec) occ_next = occ_next - OCC_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PAGES; i++) begin
                page_key[i]  <= '0;
                page_data[i] <= '0;
                page_stat[i] <= ST_FREE;
            end
            occupancy <= '0;
        end else begin
            if (flush_busy) begin
                page_key[flush_cnt]  <= '0;
                page_data[flush_cnt] <= '0;
                page_stat[flush_cnt] <= ST_FREE;
            end else if (clr_apply) begin
                page_key[clr_page_addr]  <= '0;
                page_data[clr_page_addr] <= '0;
                page_stat[clr_page_addr] <= ST_FREE;
            end
            if (wr_en) begin
                page_key[wr_addr]  <= wr_key;
                page_data[wr_addr] <= wr_data;
                page_stat[wr_addr] <= wr_stat;
            end
            occupancy <= occ_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid     <= 1'b0;
            rsp_cmd       <= '0;
            rsp_hit       <= 1'b0;
            rsp_addr      <= '0;
            rsp_data      <= '0;
            rsp_status    <= ST_FREE;
            rsp_evict     <= 1'b0;
            rsp_evict_key <= '0;
            rsp_full      <= 1'b0;
        end else begin
            rsp_valid     <= s1_valid;
            rsp_cmd       <= nx_cmd;
            rsp_hit       <= nx_hit;
            rsp_addr      <= nx_addr;
            rsp_data      <= nx_data;
            rsp_status    <= nx_status;
            rsp_evict     <= nx_evict;
            rsp_evict_key <= nx_evict_key;
            rsp_full      <= nx_full;
        end
    end

    // Flush FSM. flush_start is only blocked from requests, so the request
    // already in S1 drains at the edge that raises flush_busy; page 0 is
    // cleared at the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_state <= FL_IDLE;
            flush_busy  <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            case (flush_state)
                FL_IDLE: begin
                    if (flush_start) begin
                        flush_state <= FL_RUN;
                        flush_busy  <= 1'b1;
                        flush_cnt   <= '0;
                    end
                end
                FL_RUN: begin
                    if (flush_cnt == LAST_PG) begin
                        flush_state <= FL_IDLE;
                        flush_busy  <= 1'b0;
                        flush_cnt   <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + ADDR_ONE;
                    end
                end
                default: begin
                    flush_state <= FL_IDLE;
                    flush_busy  <= 1'b0;
                    flush_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef CACHE_CAM_EVICT_STATS_EN
    logic hit_inc, miss_inc;
    assign hit_inc  = s1_valid && (s1_cmd == CMD_LOOKUP || s1_cmd == CMD_STORE) && match_hit;
    assign miss_inc = s1_valid && (s1_cmd == CMD_LOOKUP || s1_cmd == CMD_STORE) && !match_hit;

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            evict_cnt <= '0;
        end else begin
            if (hit_inc && hit_cnt != '1)     hit_cnt   <= hit_cnt + 32'd1;
            if (miss_inc && miss_cnt != '1)   miss_cnt  <= miss_cnt + 32'd1;
            if (nx_evict && evict_cnt != '1)  evict_cnt <= evict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_cam_evict.sv
module tb_cache_cam_evict;

  localparam int PAGES = 4;
  localparam int AW    = 2;

  localparam logic [2:0] C_NOP = 3'd0, C_LOOKUP = 3'd1, C_STORE = 3'd2,
                         C_ERASE = 3'd3, C_DONE = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [2:0] req_cmd = '0;
  logic [13:0] req_key = '0;
  logic [7:0] req_data = '0;
  logic clr_en = 1'b0;
  logic [AW-1:0] clr_page_addr = '0;
  logic flush_start = 1'b0;
  logic flush_busy;
  logic rsp_valid;
  logic [2:0] rsp_cmd;
  logic rsp_hit;
  logic [AW-1:0] rsp_addr;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic rsp_evict;
  logic [13:0] rsp_evict_key;
  logic rsp_full;
  logic [AW:0] occupancy;
`ifdef CACHE_CAM_EVICT_STATS_EN
  logic stats_clr = 1'b0;
  logic [31:0] hit_cnt, miss_cnt, evict_cnt;
`endif

  int checks = 0;
  int failures = 0;

  cache_cam_evict #(.PAGES(PAGES), .KEY_WIDTH(14), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_key(req_key), .req_data(req_data),
    .clr_en(clr_en), .clr_page_addr(clr_page_addr),
    .flush_start(flush_start), .flush_busy(flush_busy),
`ifdef CACHE_CAM_EVICT_STATS_EN
    .stats_clr(stats_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt),
`endif
    .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_evict(rsp_evict), .rsp_evict_key(rsp_evict_key), .rsp_full(rsp_full),
    .occupancy(occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [13:0] key, input logic [7:0] data);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_key   = key;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_cmd   = '0;
    req_key   = '0;
    req_data  = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic [2:0] cmd, input logic hit,
                         input logic [AW-1:0] addr, input logic [7:0] data, input logic [1:0] st);
    chk({tag, "_valid"}, rsp_valid, 1'b1);
    chk({tag, "_cmd"}, rsp_cmd, cmd);
    chk({tag, "_hit"}, rsp_hit, hit);
    chk({tag, "_addr"}, rsp_addr, addr);
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_status"}, rsp_status, st);
  endtask

  int n;

  initial begin
    // reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_occ", occupancy, 3'd0);
    chk("rst_busy", flush_busy, 1'b0);
    chk("rst_rsp_addr", rsp_addr, 2'd0);

    // four back-to-back allocations
    issue(C_STORE, 14'h10, 8'd1);
    issue(C_STORE, 14'h11, 8'd2);
    chk_rsp("st10", C_STORE, 1'b0, 2'd0, 8'd1, 2'd1);
    chk("st10_occ", occupancy, 3'd1);
    issue(C_STORE, 14'h12, 8'd3);
    chk_rsp("st11", C_STORE, 1'b0, 2'd1, 8'd2, 2'd1);
    issue(C_STORE, 14'h13, 8'd4);
    chk_rsp("st12", C_STORE, 1'b0, 2'd2, 8'd3, 2'd1);
    chk("st12_occ", occupancy, 3'd3);
    tick();
    chk_rsp("st13", C_STORE, 1'b0, 2'd3, 8'd4, 2'd1);
    chk("fill_occ", occupancy, 3'd4);
    tick();
    chk("rsp_pulse_one_cycle", rsp_valid, 1'b0);

    // lookup hit
    issue(C_LOOKUP, 14'h12, 8'd0);
    tick();
    chk_rsp("lk12", C_LOOKUP, 1'b1, 2'd2, 8'd3, 2'd1);

    // NOP and reserved command echo, no hit even though key exists
    issue(C_NOP, 14'h12, 8'd0);
    tick();
    chk_rsp("nop", C_NOP, 1'b0, 2'd0, 8'd0, 2'd0);
    issue(3'd7, 14'h12, 8'd0);
    tick();
    chk_rsp("cmd7", 3'd7, 1'b0, 2'd0, 8'd0, 2'd0);

    // full table without DONE pages
    issue(C_STORE, 14'h20, 8'h55);
    tick();
    chk("full_flag", rsp_full, 1'b1);
    chk("full_evict", rsp_evict, 1'b0);
    chk("full_hit", rsp_hit, 1'b0);
    chk("full_occ", occupancy, 3'd4);
    issue(C_LOOKUP, 14'h10, 8'd0);
    tick();
    chk_rsp("full_lk10", C_LOOKUP, 1'b1, 2'd0, 8'd1, 2'd1);

    // mark DONE, then evict lowest DONE page
    issue(C_DONE, 14'h11, 8'd0);
    tick();
    chk_rsp("done11", C_DONE, 1'b1, 2'd1, 8'd2, 2'd2);
    issue(C_DONE, 14'h13, 8'd0);
    tick();
    chk_rsp("done13", C_DONE, 1'b1, 2'd3, 8'd4, 2'd2);
    issue(C_STORE, 14'h20, 8'h55);
    tick();
    chk_rsp("evict", C_STORE, 1'b0, 2'd1, 8'h55, 2'd1);
    chk("evict_flag", rsp_evict, 1'b1);
    chk("evict_key", rsp_evict_key, 14'h11);
    chk("evict_full", rsp_full, 1'b0);
    chk("evict_occ", occupancy, 3'd4);
    issue(C_LOOKUP, 14'h11, 8'd0);
    tick();
    chk_rsp("lk11_gone", C_LOOKUP, 1'b0, 2'd0, 8'd0, 2'd0);

    // erase
    issue(C_ERASE, 14'h10, 8'd0);
    tick();
    chk("erase_hit", rsp_hit, 1'b1);
    chk("erase_addr", rsp_addr, 2'd0);
    chk("erase_status", rsp_status, 2'd0);
    chk("erase_occ", occupancy, 3'd3);
    issue(C_LOOKUP, 14'h10, 8'd0);
    tick();
    chk("lk10_after_erase", rsp_hit, 1'b0);

    // clr_en on the page S1 is writing: S1 wins
    issue(C_STORE, 14'h12, 8'hAB);
    clr_en = 1'b1;
    clr_page_addr = 2'd2;
    tick();
    clr_en = 1'b0;
    chk_rsp("clr_race", C_STORE, 1'b1, 2'd2, 8'hAB, 2'd1);
    chk("clr_race_occ", occupancy, 3'd3);
    issue(C_LOOKUP, 14'h12, 8'd0);
    tick();
    chk_rsp("clr_race_lk", C_LOOKUP, 1'b1, 2'd2, 8'hAB, 2'd1);

    // plain clr_en of a DONE page
    clr_en = 1'b1;
    clr_page_addr = 2'd3;
    tick();
    clr_en = 1'b0;
    chk("clr_occ", occupancy, 3'd2);
    issue(C_LOOKUP, 14'h13, 8'd0);
    tick();
    chk("clr_lk13", rsp_hit, 1'b0);

    // refill to full, lowest FREE pages are 0 then 3
    issue(C_STORE, 14'h40, 8'd9);
    issue(C_STORE, 14'h41, 8'd10);
    chk("refill40_addr", rsp_addr, 2'd0);
    tick();
    chk("refill41_addr", rsp_addr, 2'd3);
    chk("refill_occ", occupancy, 3'd4);

    // flush
    flush_start = 1'b1;
    #1;
    chk("flush_start_ready", req_ready, 1'b0);
    tick();
    flush_start = 1'b0;
    chk("flush_busy_rise", flush_busy, 1'b1);
    chk("flush_busy_ready", req_ready, 1'b0);
    n = 0;
    while (flush_busy === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    chk("flush_busy_cycles", n, 4);
    chk("flush_occ", occupancy, 3'd0);
    chk("flush_end_ready", req_ready, 1'b1);
    issue(C_LOOKUP, 14'h20, 8'd0);
    issue(C_LOOKUP, 14'h12, 8'd0);
    chk("flush_lk20", rsp_hit, 1'b0);
    issue(C_LOOKUP, 14'h40, 8'd0);
    chk("flush_lk12", rsp_hit, 1'b0);
    issue(C_LOOKUP, 14'h41, 8'd0);
    chk("flush_lk40", rsp_hit, 1'b0);
    tick();
    chk("flush_lk41", rsp_hit, 1'b0);

    // same-key hazard on an empty table
    issue(C_STORE, 14'h30, 8'd7);
    issue(C_LOOKUP, 14'h30, 8'd0);
    chk_rsp("haz_store", C_STORE, 1'b0, 2'd0, 8'd7, 2'd1);
    tick();
    chk_rsp("haz_lookup", C_LOOKUP, 1'b1, 2'd0, 8'd7, 2'd1);

    // reset mid-flush
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    chk("mid_busy", flush_busy, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", flush_busy, 1'b0);
    rst = 1'b0;
    tick();
    tick();
    chk("mid_rst_busy_stays", flush_busy, 1'b0);
    chk("mid_rst_occ", occupancy, 3'd0);
    chk("mid_rst_ready", req_ready, 1'b1);

`ifdef CACHE_CAM_EVICT_STATS_EN
    issue(C_STORE, 14'h50, 8'd5);
    issue(C_STORE, 14'h51, 8'd6);
    issue(C_STORE, 14'h52, 8'd7);
    issue(C_STORE, 14'h53, 8'd8);
    tick();
    chk("st_fill_miss", miss_cnt, 32'd4);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr0_miss", miss_cnt, 32'd0);
    issue(C_LOOKUP, 14'h50, 8'd0);
    tick();
    issue(C_LOOKUP, 14'h51, 8'd0);
    tick();
    issue(C_STORE, 14'h52, 8'd9);
    tick();
    issue(C_DONE, 14'h53, 8'd0);
    tick();
    issue(C_STORE, 14'h60, 8'hA);
    tick();
    chk("st_evict_flag", rsp_evict, 1'b1);
    chk("st_evict_key", rsp_evict_key, 14'h53);
    issue(C_LOOKUP, 14'h99, 8'd0);
    tick();
    chk("st_hit", hit_cnt, 32'd3);
    chk("st_miss", miss_cnt, 32'd2);
    chk("st_evict", evict_cnt, 32'd1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    chk("st_clr_hit", hit_cnt, 32'd0);
    chk("st_clr_miss", miss_cnt, 32'd0);
    chk("st_clr_evict", evict_cnt, 32'd0);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
